// File: rtl/rst_seq_ctrl.sv
// Ordered reset sequencer: releases NUM_STG active-low stage resets one at a time.
// Optional macro RST_SEQ_REV_ASSERT_EN re-asserts stages in reverse order on a software request.
module rst_seq_ctrl #(
  parameter int NUM_STG  = 4,
  parameter int CNT_W    = 8,
  parameter int STG_DLY  = 16,
  parameter int SW_PULSE = 8
) (
  input  logic               i_clkin,
  input  logic               i_reset,
  input  logic               i_sw_req,
  input  logic               i_hold,
  output logic [NUM_STG-1:0] o_rst_n,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IDX_W = $clog2(NUM_STG + 1);
  localparam logic [CNT_W-1:0] PULSE_MAX = CNT_W'(SW_PULSE - 1);
  localparam logic [CNT_W-1:0] DLY_MAX   = CNT_W'(STG_DLY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STG - 1);

`ifdef RST_SEQ_REV_ASSERT_EN
  typedef enum logic [1:0] {ST_ASSERT = 2'd0, ST_RELEASE = 2'd1, ST_DONE = 2'd2, ST_DRAIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_ASSERT = 2'd0, ST_RELEASE = 2'd1, ST_DONE = 2'd2} state_t;
`endif

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [NUM_STG-1:0] rst_n_r, rst_n_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  // One-hot mask selecting stage idx (all-zero when idx is out of range).
  function automatic logic [NUM_STG-1:0] stage_bit(input logic [IDX_W-1:0] idx);
    for (int k = 0; k < NUM_STG; k++) begin
      stage_bit[k] = (idx == IDX_W'(k));
    end
  endfunction

  // Next-state, counter, index and output computation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    rst_n_s = rst_n_r;
    busy_s  = busy_r;
    done_s  = done_r;
    if (i_sw_req) begin
`ifdef RST_SEQ_REV_ASSERT_EN
      if ((state_r == ST_RELEASE && idx_r != IDX_W'(0)) || state_r == ST_DONE) begin
        rst_n_s = rst_n_r & ~stage_bit(idx_r - IDX_W'(1));
        idx_s   = idx_r - IDX_W'(1);
        cnt_s   = CNT_W'(0);
        busy_s  = 1'b1;
        done_s  = 1'b0;
        state_s = (idx_r == IDX_W'(1)) ? ST_ASSERT : ST_DRAIN;
      end else if (state_r == ST_DRAIN) begin
        // Drain continues undisturbed; a request cannot shorten it.
        if (cnt_r == DLY_MAX) begin
          rst_n_s = rst_n_r & ~stage_bit(idx_r - IDX_W'(1));
          idx_s   = idx_r - IDX_W'(1);
          cnt_s   = CNT_W'(0);
          state_s = (idx_r == IDX_W'(1)) ? ST_ASSERT : ST_DRAIN;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        state_s = ST_ASSERT;
        cnt_s   = CNT_W'(0);
        idx_s   = IDX_W'(0);
        rst_n_s = {NUM_STG{1'b0}};
        busy_s  = 1'b1;
        done_s  = 1'b0;
      end
`else
      state_s = ST_ASSERT;
      cnt_s   = CNT_W'(0);
      idx_s   = IDX_W'(0);
      rst_n_s = {NUM_STG{1'b0}};
      busy_s  = 1'b1;
      done_s  = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_ASSERT: begin
          if (cnt_r == PULSE_MAX) begin
            if (!i_hold) begin
              state_s = ST_RELEASE;
              cnt_s   = CNT_W'(0);
              idx_s   = IDX_W'(0);
            end else begin
              cnt_s = PULSE_MAX;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (i_hold) begin
            cnt_s = cnt_r;
          end else if (cnt_r == DLY_MAX) begin
            rst_n_s = rst_n_r | stage_bit(idx_r);
            cnt_s   = CNT_W'(0);
            idx_s   = idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
              busy_s  = 1'b0;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          rst_n_s = {NUM_STG{1'b1}};
        end
`ifdef RST_SEQ_REV_ASSERT_EN
        ST_DRAIN: begin
          if (cnt_r == DLY_MAX) begin
            rst_n_s = rst_n_r & ~stage_bit(idx_r - IDX_W'(1));
            idx_s   = idx_r - IDX_W'(1);
            cnt_s   = CNT_W'(0);
            state_s = (idx_r == IDX_W'(1)) ? ST_ASSERT : ST_DRAIN;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
`endif
        default: begin
          state_s = ST_ASSERT;
          cnt_s   = CNT_W'(0);
          idx_s   = IDX_W'(0);
          rst_n_s = {NUM_STG{1'b0}};
          busy_s  = 1'b1;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset asserts all stages asynchronously.
  always_ff @(posedge i_clkin or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_ASSERT;
      cnt_r   <= CNT_W'(0);
      idx_r   <= IDX_W'(0);
      rst_n_r <= {NUM_STG{1'b0}};
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      rst_n_r <= rst_n_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign o_rst_n = rst_n_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;

endmodule
